// File: rtl/dmem_line_responder.sv
// rtl/dmem_line_responder.sv - line-granular data-memory responder with fixed ack latency
// One request in flight; the line array is deliberately left out of reset.
module dmem_line_responder #(
   parameter int LINE_W  = 256,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mem_enable_i,
   input  logic              mem_write_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [LINE_W-1:0] mem_data_i,
   output logic              mem_ack_o,
   output logic [LINE_W-1:0] mem_data_o,
   output logic              busy_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t              r_state, w_next;
   logic [CNT_W-1:0]    r_cnt, w_cnt_next;
   logic                r_req_write;
   logic [IDX_W-1:0]    r_req_idx;
   logic [LINE_W-1:0]   r_req_data;
   logic [LINE_W-1:0]   r_rdata;
   logic [LINE_W-1:0]   r_mem [DEPTH];

   logic                w_accept;
   logic                w_do_op;
   logic                w_op_write;
   logic [IDX_W-1:0]    w_op_idx;
   logic [LINE_W-1:0]   w_op_data;
   logic [IDX_W-1:0]    w_addr_idx;
   logic                w_unused;

   assign w_addr_idx = mem_addr_i[5 +: IDX_W];
   assign w_unused   = ^{mem_addr_i[4:0], mem_addr_i[ADDR_W-1:5+IDX_W]};

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_accept   = 1'b0;
      w_do_op    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_enable_i) begin
               w_accept = 1'b1;
               if (LATENCY == 1) begin
                  w_next  = S_ACK;
                  w_do_op = 1'b1;
               end else begin
                  w_next     = S_WAIT;
                  w_cnt_next = CNT_W'(1);
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == CNT_LAST) begin
               w_next  = S_ACK;
               w_do_op = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         S_ACK: begin
            w_next     = S_IDLE;
            w_cnt_next = '0;
         end
         default: begin
            w_next     = S_IDLE;
            w_cnt_next = '0;
         end
      endcase
   end

   // With LATENCY==1 the array op happens on the accepting edge, so it must use the live inputs
   assign w_op_write = (r_state == S_IDLE) ? mem_write_i : r_req_write;
   assign w_op_idx   = (r_state == S_IDLE) ? w_addr_idx  : r_req_idx;
   assign w_op_data  = (r_state == S_IDLE) ? mem_data_i  : r_req_data;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_req_write <= 1'b0;
         r_req_idx   <= '0;
         r_req_data  <= '0;
         r_rdata     <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_req_write <= mem_write_i;
            r_req_idx   <= w_addr_idx;
            r_req_data  <= mem_data_i;
         end
         if (w_do_op && !w_op_write)
            r_rdata <= r_mem[w_op_idx];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && w_do_op && w_op_write)
         r_mem[w_op_idx] <= w_op_data;
   end

   assign mem_ack_o  = (r_state == S_ACK);
   assign busy_o     = (r_state != S_IDLE);
   assign mem_data_o = r_rdata;

endmodule

// File: tb/tb_dmem_line_responder.sv
// tb/tb_dmem_line_responder.sv - directed vector bench for dmem_line_responder
// Two instances: default LATENCY=10, and LATENCY=1 for back-to-back requests.
module tb_dmem_line_responder;

   localparam int LW  = 256;
   localparam int LAT = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0, wr = 1'b0;
   logic [31:0]   addr = '0;
   logic [LW-1:0] wdata = '0;
   logic          ack, busy;
   logic [LW-1:0] rdata;

   logic          en1 = 1'b0, wr1 = 1'b0;
   logic [31:0]   addr1 = '0;
   logic [LW-1:0] wdata1 = '0;
   logic          ack1, busy1;
   logic [LW-1:0] rdata1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_line_responder #(.LATENCY(LAT)) u_dut (
      .clk_i(clk), .rst_i(rst), .mem_enable_i(en), .mem_write_i(wr),
      .mem_addr_i(addr), .mem_data_i(wdata),
      .mem_ack_o(ack), .mem_data_o(rdata), .busy_o(busy)
   );

   dmem_line_responder #(.LATENCY(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .mem_enable_i(en1), .mem_write_i(wr1),
      .mem_addr_i(addr1), .mem_data_i(wdata1),
      .mem_ack_o(ack1), .mem_data_o(rdata1), .busy_o(busy1)
   );

   typedef struct {
      logic          wr;
      logic [31:0]   addr;
      logic [LW-1:0] data;
      logic [LW-1:0] exp;
      logic          corrupt;
   } vec_t;

   vec_t          vec [8];
   logic [LW-1:0] last_rd;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_req(input vec_t v, input int id);
      int   n;
      logic got;
      logic busy_ok;
      @(negedge clk);
      en = 1'b1; wr = v.wr; addr = v.addr; wdata = v.data;
      @(posedge clk);
      if (v.corrupt) begin
         #1 en = 1'b0; wdata = '0;
      end
      n = 0; got = 1'b0; busy_ok = 1'b1;
      while (!got && n < 50) begin
         @(negedge clk);
         n++;
         if (ack) got = 1'b1;
         else if (!busy) busy_ok = 1'b0;
      end
      chk($sformatf("v%0d ack_latency", id), LW'(got ? n : 0), LW'(LAT));
      chk($sformatf("v%0d busy_wait", id), LW'(busy_ok & busy), LW'(1));
      if (!v.wr) last_rd = v.exp;
      chk($sformatf("v%0d data_at_ack", id), rdata, last_rd);
      en = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d ack_width", id), LW'(ack), LW'(0));
      chk($sformatf("v%0d busy_idle", id), LW'(busy), LW'(0));
      chk($sformatf("v%0d data_hold", id), rdata, last_rd);
   endtask

   initial begin
      int   pulses;
      logic seen;
      vec[0] = '{1'b1, 32'h40,   {32{8'hA5}}, '0,          1'b0};
      vec[1] = '{1'b0, 32'h40,   '0,          {32{8'hA5}}, 1'b0};
      vec[2] = '{1'b0, 32'h5F,   '0,          {32{8'hA5}}, 1'b0};
      vec[3] = '{1'b1, 32'h0,    LW'(1),      '0,          1'b0};
      vec[4] = '{1'b0, 32'h4000, '0,          LW'(1),      1'b0};
      vec[5] = '{1'b1, 32'h80,   LW'(8'hFF),  '0,          1'b1};
      vec[6] = '{1'b0, 32'h80,   '0,          LW'(8'hFF),  1'b0};
      vec[7] = '{1'b1, 32'hC0,   {32{8'h33}}, '0,          1'b0};
      last_rd = '0;

      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      chk("reset ack", LW'(ack), LW'(0));
      chk("reset busy", LW'(busy), LW'(0));
      chk("reset data", rdata, '0);

      for (int i = 0; i < 8; i++) do_req(vec[i], i);

      // Reset three edges into a write must drop it and clear outputs at once
      @(negedge clk);
      en = 1'b1; wr = 1'b1; addr = 32'hC0; wdata = LW'(7);
      @(posedge clk);
      #1 en = 1'b0;
      @(posedge clk); @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort busy", LW'(busy), LW'(0));
      chk("abort ack", LW'(ack), LW'(0));
      chk("abort data", rdata, '0);
      @(negedge clk);
      rst = 1'b0;
      last_rd = '0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (ack) seen = 1'b1;
      end
      chk("abort no_ack", LW'(seen), LW'(0));
      do_req('{1'b0, 32'hC0, '0, {32{8'h33}}, 1'b0}, 8);

      // LATENCY=1: enable held continuously, four writes then four reads
      @(negedge clk);
      en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h100; wdata1 = {8{32'hC0DE0000}};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("t6 wr%0d ack", i), LW'(ack1), LW'(1));
         if (i < 3) begin
            addr1  = 32'h100 + 32'((i + 1) * 32);
            wdata1 = {8{32'hC0DE0000 + 32'(i + 1)}};
         end else begin
            en1 = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("t6 wr%0d gap", i), LW'(ack1), LW'(0));
      end
      @(negedge clk);
      en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h100;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (ack1) pulses++;
         chk($sformatf("t6 rd%0d data", i), rdata1, {8{32'hC0DE0000 + 32'(i)}});
         if (i < 3) addr1 = 32'h100 + 32'((i + 1) * 32);
         else en1 = 1'b0;
         @(negedge clk);
         if (ack1) pulses++;
         chk($sformatf("t6 rd%0d busy_gap", i), LW'(busy1), LW'(0));
      end
      chk("t6 pulse_count", LW'(pulses), LW'(4));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
